// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
//   Shared definitions for the WISC-SP13 inter-stage pipeline registers.
//   Holds the control-word bit positions that every stage agrees on and the
//   payload widths used when pipe_stage_reg is dropped between two stages.
//
//   No ports (package).
// ---------------------------------------------------------------------------
package pipe_pkg;

    // Control-word bit positions. The halt flag sits at bit 0 so that the
    // stage register's default HALT_BIT lines up with the decoder output.
    localparam int CTRL_HALT     = 0;
    localparam int CTRL_JUMP     = 1;
    localparam int CTRL_MEMTOREG = 2;
    localparam int CTRL_REGWRITE = 3;
    localparam int CTRL_MEMWRITE = 4;
    localparam int CTRL_BRANCH   = 5;
    localparam int CTRL_ALUSRC   = 6;
    localparam int CTRL_MEMREAD  = 7;

    // Width of the control word carried alongside every payload.
    localparam int PIPE_CTRL_W = 8;

    // Per-stage payload widths for the 16-bit WISC-SP13 datapath.
    //   IF/ID : pc + instruction
    //   ID/EX : pc + read data 1 + read data 2 / immediate
    //   EX/M  : pc + alu result + store data
    //   M/W   : pc + alu result + load data
    localparam int IFID_DATA_W = 32;
    localparam int IDEX_DATA_W = 48;
    localparam int EXM_DATA_W  = 48;
    localparam int MW_DATA_W   = 48;

    // Generic defaults used when a stage register is instantiated without
    // explicit overrides.
    localparam int PIPE_DATA_W = 48;
    localparam int PIPE_CNT_W  = 16;

    // Identifies which boundary a stage register sits on; handy when a
    // wrapper wants to pick the payload width from a single selector.
    typedef enum logic [1:0] {
        STAGE_IFID = 2'd0,
        STAGE_IDEX = 2'd1,
        STAGE_EXM  = 2'd2,
        STAGE_MW   = 2'd3
    } pipe_stage_e;

    // Payload width for a given stage boundary.
    function automatic int stage_data_w(input pipe_stage_e stage);
        int width;
        width = PIPE_DATA_W;
        case (stage)
            STAGE_IFID: width = IFID_DATA_W;
            STAGE_IDEX: width = IDEX_DATA_W;
            STAGE_EXM:  width = EXM_DATA_W;
            STAGE_MW:   width = MW_DATA_W;
            default:    width = PIPE_DATA_W;
        endcase
        return width;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// ---------------------------------------------------------------------------
// pipe_slot
//   One storage entry of a pipeline register: a valid bit plus the payload
//   and control words that travel with it. Used for both the main (head)
//   entry and the optional skid entry of pipe_stage_reg.
//
//   Ports
//     clk     in   1       clock, rising edge
//     rst     in   1       asynchronous, active-low reset
//     load    in   1       capture d_data/d_ctrl and mark the slot valid
//     clear   in   1       mark the slot empty (wins over load)
//     d_data  in   DATA_W  payload to capture
//     d_ctrl  in   CTRL_W  control word to capture
//     valid   out  1       slot holds an entry
//     data    out  DATA_W  held payload
//     ctrl    out  CTRL_W  held control word (raw, not gated by valid)
// ---------------------------------------------------------------------------
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int CTRL_W = PIPE_CTRL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] d_data,
    input  logic [CTRL_W-1:0] d_ctrl,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);

    // The payload registers only change on load, so a cleared slot keeps its
    // stale contents; the owner is expected to gate anything that matters
    // (the control word) with the valid bit before it leaves the stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            data  <= '0;
            ctrl  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= d_data;
            ctrl  <= d_ctrl;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//   Parametrised inter-stage pipeline register for the WISC-SP13 core
//   (IF/ID, ID/EX, EX/M, M/W). Moves a payload word and a control word with
//   a valid/ready handshake, optionally through a one-entry skid buffer so
//   that in_ready is a pure register output. Also provides a synchronous
//   flush (bubble insertion), a sticky halt flag and a saturating stall
//   counter.
//
//   Ports
//     clk        in   1       clock, rising edge
//     rst        in   1       asynchronous, active-low reset
//     flush      in   1       kill every held entry and the one offered now
//     in_valid   in   1       upstream entry valid
//     in_ready   out  1       stage can accept this cycle
//     in_data    in   DATA_W  upstream payload
//     in_ctrl    in   CTRL_W  upstream control bits
//     out_valid  out  1       entry presented downstream
//     out_ready  in   1       downstream accepts
//     out_data   out  DATA_W  payload of head entry
//     out_ctrl   out  CTRL_W  control of head entry; 0 when !out_valid
//     halted     out  1       sticky: a halt entry has left the stage
//     stall_cnt  out  CNT_W   saturating count of stalled output cycles
// ---------------------------------------------------------------------------
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W   = PIPE_DATA_W,
    parameter int CTRL_W   = PIPE_CTRL_W,
    parameter int HALT_BIT = CTRL_HALT,
    parameter int SKID     = 1,
    parameter int CNT_W    = PIPE_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Main (head) slot
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic [CTRL_W-1:0] m_ctrl;
    logic              m_load;
    logic              m_clear;
    logic [DATA_W-1:0] m_d_data;
    logic [CTRL_W-1:0] m_d_ctrl;

    // Skid slot (tied off when SKID=0)
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic [CTRL_W-1:0] s_ctrl;
    logic              s_load;
    logic              s_clear;

    // Handshake events
    logic              accept;
    logic              emit;
    logic              main_free;

    // Head entry is always the main slot; its control word is forced to zero
    // when the slot is empty so that a bubble can never assert RegWrite or
    // MemWrite downstream, even though the payload register keeps old data.
    assign out_valid = m_valid;
    assign out_data  = m_data;
    assign out_ctrl  = m_valid ? m_ctrl : '0;

    // Slot steering. The main slot refills whenever it is empty or being
    // drained this cycle, taking the skid entry first because the skid entry
    // is always older than whatever is offered on the input. The skid slot
    // only catches an accepted entry when the main slot is full and stuck.
    // Flush overrides everything: both slots empty and the offered entry is
    // dropped even if it was handshaken.
    always_comb begin
        accept    = in_valid & in_ready;
        emit      = m_valid & out_ready;
        main_free = !m_valid | emit;
        m_load    = 1'b0;
        m_clear   = 1'b0;
        s_load    = 1'b0;
        s_clear   = 1'b0;
        if (flush) begin
            m_clear = 1'b1;
            s_clear = 1'b1;
        end else if (main_free) begin
            if (s_valid) begin
                m_load  = 1'b1;
                s_clear = 1'b1;
            end else if (accept) begin
                m_load  = 1'b1;
            end else begin
                m_clear = 1'b1;
            end
        end else if (accept) begin
            s_load = 1'b1;
        end
    end

    // The main slot is fed from the skid entry when one is waiting,
    // otherwise straight from the input.
    assign m_d_data = s_valid ? s_data : in_data;
    assign m_d_ctrl = s_valid ? s_ctrl : in_ctrl;

    pipe_slot #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_main (
        .clk    (clk),
        .rst    (rst),
        .load   (m_load),
        .clear  (m_clear),
        .d_data (m_d_data),
        .d_ctrl (m_d_ctrl),
        .valid  (m_valid),
        .data   (m_data),
        .ctrl   (m_ctrl)
    );

    // With a skid slot, in_ready depends only on flops (skid empty, not
    // halted), which breaks the combinational ready chain through the
    // pipeline. Without it, in_ready looks through to out_ready so a full
    // slot can still accept while it is being drained. In both variants the
    // stage refuses entries while reset is asserted.
    generate
        if (SKID != 0) begin : g_skid
            pipe_slot #(
                .DATA_W (DATA_W),
                .CTRL_W (CTRL_W)
            ) u_skid (
                .clk    (clk),
                .rst    (rst),
                .load   (s_load),
                .clear  (s_clear),
                .d_data (in_data),
                .d_ctrl (in_ctrl),
                .valid  (s_valid),
                .data   (s_data),
                .ctrl   (s_ctrl)
            );

            assign in_ready = rst & !halted & !s_valid;
        end else begin : g_no_skid
            assign s_valid  = 1'b0;
            assign s_data   = '0;
            assign s_ctrl   = '0;
            assign in_ready = rst & !halted & (out_ready | !m_valid);
        end
    endgenerate

    // Halt is recorded when the halt entry actually leaves the stage, not
    // when it arrives, so the instruction is guaranteed to have been handed
    // downstream. Only reset clears it; flush deliberately leaves it set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            halted <= 1'b0;
        end else if (emit && out_ctrl[HALT_BIT]) begin
            halted <= 1'b1;
        end
    end

    // Counts cycles where an entry is presented but not taken. A cycle that
    // is being flushed is not a stall because the entry is discarded. The
    // counter sticks at its maximum rather than wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (m_valid && !out_ready && !flush && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg
//   Drives three pipe_stage_reg instances from one shared stimulus stream:
//     inst 0 : SKID=1, CNT_W=16
//     inst 1 : SKID=0, CNT_W=16
//     inst 2 : SKID=1, CNT_W=4
//   Each instance is shadowed by a FIFO-style model: an ordered list of at
//   most two held entries plus a halt flag and a stall count.
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;

    localparam int DW       = 48;
    localparam int CW       = 8;
    localparam int HALT_IDX = 0;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_ready;

    logic          rdy [3];
    logic          ov  [3];
    logic [DW-1:0] od  [3];
    logic [CW-1:0] oc  [3];
    logic          hl  [3];
    logic [15:0]   sc0;
    logic [15:0]   sc1;
    logic [3:0]    sc2;

    int checks   = 0;
    int failures = 0;

    // Reference model state per instance
    int            m_cnt  [3];
    logic [DW-1:0] m_qd   [3][2];
    logic [CW-1:0] m_qc   [3][2];
    logic          m_halt [3];
    int            m_stall[3];

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .HALT_BIT(0), .SKID(1), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy[0]),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(ov[0]), .out_ready(out_ready),
        .out_data(od[0]), .out_ctrl(oc[0]), .halted(hl[0]), .stall_cnt(sc0)
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .HALT_BIT(0), .SKID(0), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy[1]),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(ov[1]), .out_ready(out_ready),
        .out_data(od[1]), .out_ctrl(oc[1]), .halted(hl[1]), .stall_cnt(sc1)
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .HALT_BIT(0), .SKID(1), .CNT_W(4)) u_dut2 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy[2]),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(ov[2]), .out_ready(out_ready),
        .out_data(od[2]), .out_ctrl(oc[2]), .halted(hl[2]), .stall_cnt(sc2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit hasSkid(input int k);
        return (k != 1);
    endfunction

    function automatic int stallMax(input int k);
        return (k == 2) ? 15 : 65535;
    endfunction

    function automatic logic [63:0] dutStall(input int k);
        logic [63:0] v;
        v = 64'd0;
        case (k)
            0:       v = {48'd0, sc0};
            1:       v = {48'd0, sc1};
            default: v = {60'd0, sc2};
        endcase
        return v;
    endfunction

    // Capacity rule: a skid stage holds two entries; a plain stage holds one
    // but can take a new one in the same cycle its entry leaves.
    function automatic logic modelReady(input int k);
        logic r;
        if (!rst || m_halt[k]) r = 1'b0;
        else if (hasSkid(k))   r = (m_cnt[k] < 2);
        else                   r = (m_cnt[k] == 0) || out_ready;
        return r;
    endfunction

    task automatic modelReset();
        for (int k = 0; k < 3; k++) begin
            m_cnt[k]   = 0;
            m_halt[k]  = 1'b0;
            m_stall[k] = 0;
            for (int j = 0; j < 2; j++) begin
                m_qd[k][j] = '0;
                m_qc[k][j] = '0;
            end
        end
    endtask

    // One clock edge of the model, evaluated with the inputs currently driven.
    task automatic modelAdvance();
        logic acc;
        logic em;
        for (int k = 0; k < 3; k++) begin
            acc = in_valid && modelReady(k);
            em  = (m_cnt[k] > 0) && out_ready;
            if (em && m_qc[k][0][HALT_IDX]) m_halt[k] = 1'b1;
            if ((m_cnt[k] > 0) && !out_ready && !flush && (m_stall[k] < stallMax(k)))
                m_stall[k]++;
            if (flush) begin
                m_cnt[k] = 0;
            end else begin
                if (em) begin
                    m_qd[k][0] = m_qd[k][1];
                    m_qc[k][0] = m_qc[k][1];
                    m_cnt[k]--;
                end
                if (acc) begin
                    m_qd[k][m_cnt[k]] = in_data;
                    m_qc[k][m_cnt[k]] = in_ctrl;
                    m_cnt[k]++;
                end
            end
        end
    endtask

    task automatic checkVal(input string tag, input int k, input logic [63:0] observed,
                            input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s inst%0d observed=%0h expected=%0h t=%0t",
                   tag, k, observed, expected, $time);
        end
    endtask

    task automatic checkOutput();
        for (int k = 0; k < 3; k++) begin
            checkVal("in_ready", k, {63'd0, rdy[k]}, {63'd0, modelReady(k)});
            checkVal("out_valid", k, {63'd0, ov[k]}, {63'd0, (m_cnt[k] > 0)});
            checkVal("out_ctrl", k, {56'd0, oc[k]}, (m_cnt[k] > 0) ? {56'd0, m_qc[k][0]} : 64'd0);
            if (m_cnt[k] > 0)
                checkVal("out_data", k, {16'd0, od[k]}, {16'd0, m_qd[k][0]});
            checkVal("halted", k, {63'd0, hl[k]}, {63'd0, m_halt[k]});
            checkVal("stall_cnt", k, dutStall(k), 64'(m_stall[k]));
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                                 input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = r;
        flush     = f;
        #1;
        checkOutput();
        modelAdvance();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Asynchronous reset asserted between clock edges, checked before any
    // edge can occur, then released on a falling edge.
    task automatic doReset();
        #2;
        rst = 1'b0;
        #1;
        modelReset();
        checkOutput();
        for (int k = 0; k < 3; k++)
            checkVal("rst_data", k, {16'd0, od[k]}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [DW-1:0] rd;
        logic [CW-1:0] rc;

        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_ctrl   = '0;
        out_ready = 1'b0;
        modelReset();
        @(negedge clk);
        doReset();

        $display("[TB] streaming 1..16 with ready held high");
        for (int i = 1; i <= 16; i++)
            applyStimulus(1'b1, DW'(i), 8'h08, 1'b1, 1'b0);
        applyStimulus(1'b1, 48'h11, 8'h0C, 1'b0, 1'b0);
        applyStimulus(1'b0, 48'h0, 8'h00, 1'b0, 1'b0);

        $display("[TB] reset while entries held");
        doReset();
        applyStimulus(1'b0, 48'h0, 8'h00, 1'b1, 1'b0);

        $display("[TB] backpressure A B C");
        applyStimulus(1'b1, 48'hA, 8'h08, 1'b0, 1'b0);
        applyStimulus(1'b1, 48'hB, 8'h08, 1'b0, 1'b0);
        applyStimulus(1'b1, 48'hC, 8'h08, 1'b0, 1'b0);
        applyStimulus(1'b1, 48'hC, 8'h08, 1'b0, 1'b0);
        applyStimulus(1'b1, 48'hC, 8'h08, 1'b1, 1'b0);
        applyStimulus(1'b1, 48'hC, 8'h08, 1'b1, 1'b0);
        applyStimulus(1'b0, 48'h0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b0, 48'h0, 8'h00, 1'b1, 1'b0);

        $display("[TB] flush with both slots full");
        applyStimulus(1'b1, 48'h101, 8'h18, 1'b0, 1'b0);
        applyStimulus(1'b1, 48'h102, 8'h18, 1'b0, 1'b0);
        applyStimulus(1'b1, 48'h103, 8'h18, 1'b0, 1'b1);
        applyStimulus(1'b0, 48'h0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b0, 48'h0, 8'h00, 1'b1, 1'b0);

        $display("[TB] halt with skid entry draining");
        doReset();
        applyStimulus(1'b1, 48'hAA, 8'h01, 1'b0, 1'b0);
        applyStimulus(1'b1, 48'hBB, 8'h08, 1'b0, 1'b0);
        applyStimulus(1'b0, 48'h0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b1, 48'hCC, 8'h08, 1'b1, 1'b0);
        applyStimulus(1'b1, 48'hDD, 8'h08, 1'b1, 1'b0);
        applyStimulus(1'b1, 48'hEE, 8'h08, 1'b0, 1'b1);
        applyStimulus(1'b1, 48'hEE, 8'h08, 1'b1, 1'b0);

        $display("[TB] stall counter saturation");
        doReset();
        applyStimulus(1'b1, 48'h7, 8'h04, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++)
            applyStimulus(1'b0, 48'h0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b0, 48'h0, 8'h00, 1'b1, 1'b0);

        $display("[TB] randomized traffic");
        doReset();
        for (int i = 0; i < 400; i++) begin
            if ((i % 80) == 79) doReset();
            rd    = {16'($urandom), $urandom};
            rc    = 8'($urandom);
            rc[0] = ($urandom_range(0, 39) == 0);
            applyStimulus(($urandom_range(0, 3) != 0), rd, rc,
                          ($urandom_range(0, 9) < 7), ($urandom_range(0, 11) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
